// File: rtl/mux_4x1_rr_stream.sv
// Four-source valid/ready stream merger with round-robin arbitration, packet lock
// and a single registered output stage tagged with the source index.
module mux_4x1_rr_stream #(
  parameter int unsigned WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [3:0]         in_valid,
  output logic [3:0]         in_ready,
  input  logic [4*WIDTH-1:0] in_data,
  input  logic [3:0]         in_last,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic               out_last,
  output logic [1:0]         out_sel,
  output logic               busy
);

  typedef enum logic [0:0] {StIdle, StLocked} state_e;

  state_e            state_q, state_d;
  logic [1:0]        ptr_q, ptr_d;
  logic [1:0]        lock_q, lock_d;
  logic              out_valid_q, out_valid_d;
  logic [WIDTH-1:0]  out_data_q, out_data_d;
  logic              out_last_q, out_last_d;
  logic [1:0]        out_sel_q, out_sel_d;

  logic              load_en;
  logic              gnt_found;
  logic [1:0]        gnt_idx;
  logic [1:0]        sel;
  logic              xfer;
  logic              sel_last;
  logic [WIDTH-1:0]  sel_data;

  assign load_en = !out_valid_q || out_ready;

  // Round-robin search starting at ptr_q; first valid channel wins.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = ptr_q;
    for (int k = 0; k < 4; k++) begin
      logic [1:0] idx;
      idx = ptr_q + 2'(k);
      if (!gnt_found && in_valid[idx]) begin
        gnt_found = 1'b1;
        gnt_idx   = idx;
      end
    end
  end

  assign sel      = (state_q == StLocked) ? lock_q : gnt_idx;
  assign sel_data = in_data[int'(sel)*WIDTH +: WIDTH];
  assign sel_last = in_last[sel];

  // A locked channel is offered ready regardless of its own valid.
  always_comb begin
    in_ready = 4'b0000;
    if (state_q == StLocked) begin
      in_ready[lock_q] = load_en;
    end else if (gnt_found) begin
      in_ready[gnt_idx] = load_en;
    end
  end

  assign xfer = in_valid[sel] && in_ready[sel];

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    lock_d      = lock_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    out_sel_d   = out_sel_q;

    if (load_en) begin
      out_valid_d = xfer;
      if (xfer) begin
        out_data_d = sel_data;
        out_last_d = sel_last;
        out_sel_d  = sel;
      end
    end

    if (xfer) begin
      unique case (state_q)
        StIdle: begin
          if (sel_last) begin
            ptr_d = sel + 2'd1;
          end else begin
            state_d = StLocked;
            lock_d  = sel;
          end
        end
        StLocked: begin
          if (sel_last) begin
            state_d = StIdle;
            ptr_d   = lock_q + 2'd1;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      ptr_q       <= 2'd0;
      lock_q      <= 2'd0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      out_sel_q   <= 2'd0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      lock_q      <= lock_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      out_sel_q   <= out_sel_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;
  assign out_sel   = out_sel_q;
  assign busy      = (state_q == StLocked);

endmodule

// File: tb/tb_mux_4x1_rr_stream.sv
// Directed bench for mux_4x1_rr_stream: arbitration order, packet lock, backpressure,
// reset mid-packet and a locked channel that stalls.
module tb_mux_4x1_rr_stream;

  localparam int unsigned WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic [3:0]       in_valid;
  logic [3:0]       in_ready;
  logic [4*WIDTH-1:0] in_data;
  logic [3:0]       in_last;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_last;
  logic [1:0]       out_sel;
  logic             busy;

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  mux_4x1_rr_stream #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .out_sel   (out_sel),
    .busy      (busy)
  );

  // Advance one clock; inputs are changed and outputs sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; in_valid = 4'b0; in_last = 4'b0; in_data = '0; out_ready = 1'b1;
    step(); step();
    rst = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    checks++; if (out_data !== 8'h00) begin fails++; $display("FAIL reset_out_data got %h want 00", out_data); end
    checks++; if (out_last !== 1'b0) begin fails++; $display("FAIL reset_out_last got %b want 0", out_last); end
    checks++; if (out_sel !== 2'd0) begin fails++; $display("FAIL reset_out_sel got %0d want 0", out_sel); end
    checks++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (in_ready !== 4'b0000) begin fails++; $display("FAIL reset_in_ready got %b want 0000", in_ready); end
  endtask

  task automatic test_round_robin();
    do_reset();
    in_valid = 4'b1111; in_last = 4'b1111; in_data = 32'hA3A2A1A0; out_ready = 1'b1;
    #1;
    checks++; if (in_ready !== 4'b0001) begin fails++; $display("FAIL rr_first_ready got %b want 0001", in_ready); end
    for (int k = 0; k < 5; k++) begin
      step();
      checks++; if (out_valid !== 1'b1) begin fails++; $display("FAIL rr_valid[%0d] got %b want 1", k, out_valid); end
      checks++; if (out_sel !== 2'(k % 4)) begin fails++; $display("FAIL rr_sel[%0d] got %0d want %0d", k, out_sel, k % 4); end
      checks++; if (out_data !== 8'(8'hA0 + k % 4)) begin fails++; $display("FAIL rr_data[%0d] got %h want %h", k, out_data, 8'hA0 + k % 4); end
    end
    in_valid = 4'b0000;
    step();
    checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL rr_drain_valid got %b want 0", out_valid); end
  endtask

  task automatic test_packet_lock();
    logic [7:0] beats [3];
    beats[0] = 8'hA1; beats[1] = 8'hA2; beats[2] = 8'hA3;
    do_reset();
    // Single-beat packet on ch1 moves the pointer to 2.
    in_valid = 4'b0010; in_last = 4'b1111; in_data = 32'h00001100; out_ready = 1'b1;
    step();
    in_valid = 4'b0101; in_data = 32'h00A100C0; in_last = 4'b0001;
    for (int k = 0; k < 3; k++) begin
      in_data[16 +: 8] = beats[k];
      in_last[2] = (k == 2);
      #1;
      checks++; if (in_ready !== 4'b0100) begin fails++; $display("FAIL lock_ready[%0d] got %b want 0100", k, in_ready); end
      step();
      checks++; if (out_data !== beats[k]) begin fails++; $display("FAIL lock_data[%0d] got %h want %h", k, out_data, beats[k]); end
      checks++; if (out_sel !== 2'd2) begin fails++; $display("FAIL lock_sel[%0d] got %0d want 2", k, out_sel); end
      checks++; if (busy !== (k != 2)) begin fails++; $display("FAIL lock_busy[%0d] got %b want %b", k, busy, k != 2); end
    end
    #1;
    checks++; if (in_ready !== 4'b0001) begin fails++; $display("FAIL lock_next_ready got %b want 0001", in_ready); end
    step();
    checks++; if (out_data !== 8'hC0 || out_sel !== 2'd0) begin fails++; $display("FAIL lock_next_beat got %h/%0d want c0/0", out_data, out_sel); end
  endtask

  task automatic test_backpressure();
    do_reset();
    in_valid = 4'b1111; in_last = 4'b1111; in_data = 32'h44332211; out_ready = 1'b0;
    step();
    checks++; if (out_valid !== 1'b1 || out_data !== 8'h11 || out_sel !== 2'd0) begin fails++; $display("FAIL bp_load got %b/%h/%0d want 1/11/0", out_valid, out_data, out_sel); end
    for (int k = 0; k < 5; k++) begin
      checks++; if (in_ready !== 4'b0000) begin fails++; $display("FAIL bp_ready[%0d] got %b want 0000", k, in_ready); end
      step();
      checks++; if (out_valid !== 1'b1 || out_data !== 8'h11 || out_sel !== 2'd0 || out_last !== 1'b1) begin
        fails++; $display("FAIL bp_hold[%0d] got %b/%h/%0d/%b want 1/11/0/1", k, out_valid, out_data, out_sel, out_last);
      end
    end
    out_ready = 1'b1;
    #1;
    checks++; if (in_ready !== 4'b0010) begin fails++; $display("FAIL bp_resume_ready got %b want 0010", in_ready); end
    step();
    checks++; if (out_valid !== 1'b1 || out_data !== 8'h22 || out_sel !== 2'd1) begin fails++; $display("FAIL bp_resume got %b/%h/%0d want 1/22/1", out_valid, out_data, out_sel); end
  endtask

  task automatic test_alternating_ready();
    logic [7:0] beats [3];
    logic [7:0] seen [$];
    int idx;
    beats[0] = 8'h11; beats[1] = 8'h22; beats[2] = 8'h33;
    do_reset();
    idx = 0;
    for (int cyc = 0; cyc < 20; cyc++) begin
      out_ready = cyc[0];
      in_valid  = (idx < 3) ? 4'b0010 : 4'b0000;
      in_data   = '0;
      in_last   = 4'b0000;
      if (idx < 3) begin
        in_data[8 +: 8] = beats[idx];
        in_last[1]      = (idx == 2);
      end
      #1;
      if (out_valid && out_ready) seen.push_back(out_data);
      if (in_valid[1] && in_ready[1]) idx++;
      step();
    end
    checks++; if (seen.size() !== 3) begin fails++; $display("FAIL alt_count got %0d want 3", seen.size()); end
    for (int k = 0; k < 3; k++) begin
      if (k < seen.size()) begin
        checks++; if (seen[k] !== beats[k]) begin fails++; $display("FAIL alt_data[%0d] got %h want %h", k, seen[k], beats[k]); end
      end
    end
  endtask

  task automatic test_reset_mid_packet();
    do_reset();
    in_valid = 4'b1000; in_last = 4'b0000; in_data = 32'hD3000000; out_ready = 1'b1;
    step();
    checks++; if (busy !== 1'b1 || out_sel !== 2'd3) begin fails++; $display("FAIL rstmid_locked got %b/%0d want 1/3", busy, out_sel); end
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++; if (out_valid !== 1'b0 || busy !== 1'b0) begin fails++; $display("FAIL rstmid_clear got %b/%b want 0/0", out_valid, busy); end
    in_valid = 4'b1001; in_last = 4'b1111; in_data = 32'hD30000E0;
    #1;
    checks++; if (in_ready !== 4'b0001) begin fails++; $display("FAIL rstmid_ready got %b want 0001", in_ready); end
    step();
    checks++; if (out_sel !== 2'd0 || out_data !== 8'hE0) begin fails++; $display("FAIL rstmid_grant got %0d/%h want 0/e0", out_sel, out_data); end
  endtask

  task automatic test_locked_stall();
    do_reset();
    in_valid = 4'b0010; in_last = 4'b0000; in_data = 32'h00005100; out_ready = 1'b1;
    step();
    in_valid = 4'b0001; in_last = 4'b0001; in_data = 32'h000052F0;
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++; if (in_ready !== 4'b0010) begin fails++; $display("FAIL stall_ready[%0d] got %b want 0010", k, in_ready); end
      step();
      checks++; if (out_valid !== 1'b0 || busy !== 1'b1) begin fails++; $display("FAIL stall_out[%0d] got %b/%b want 0/1", k, out_valid, busy); end
    end
    in_valid = 4'b0011; in_last = 4'b0011;
    #1;
    checks++; if (in_ready !== 4'b0010) begin fails++; $display("FAIL stall_last_ready got %b want 0010", in_ready); end
    step();
    checks++; if (out_valid !== 1'b1 || out_sel !== 2'd1 || out_data !== 8'h52 || out_last !== 1'b1 || busy !== 1'b0) begin
      fails++; $display("FAIL stall_last got %b/%0d/%h/%b/%b want 1/1/52/1/0", out_valid, out_sel, out_data, out_last, busy);
    end
    in_valid = 4'b0001;
    #1;
    checks++; if (in_ready !== 4'b0001) begin fails++; $display("FAIL stall_ch0_ready got %b want 0001", in_ready); end
    step();
    checks++; if (out_sel !== 2'd0 || out_data !== 8'hF0) begin fails++; $display("FAIL stall_ch0 got %0d/%h want 0/f0", out_sel, out_data); end
  endtask

  initial begin
    rst = 1'b1; in_valid = '0; in_last = '0; in_data = '0; out_ready = 1'b0;
    test_reset();
    test_round_robin();
    test_packet_lock();
    test_backpressure();
    test_alternating_ready();
    test_reset_mid_packet();
    test_locked_stall();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
